// File: rtl/vga_timing_gen.sv
// Purpose: run-time reconfigurable VGA timing generator (counters, sync, blank, de, line/frame pulses).
// Latency: counts and flags are registered together from the next-count value, so they have zero skew.
// Backpressure: cfg_ready drops while a new mode waits for the frame boundary; pix_en=0 freezes timing.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   pix_en                   pixel-clock enable; counters and flags advance only when high
//   cfg_valid / cfg_ready    mode-offer handshake
//   cfg_h_* / cfg_v_*        offered horizontal / vertical act, fp, sync, bp fields
//   cfg_err                  one-cycle pulse when an offered mode is rejected
//   hcount, vcount           current pixel position
//   hsync, vsync, hblnk, vblnk, de   timing flags aligned with the counts
//   line_start, frame_start  one-cycle pulses on the transition to hcount=0 / (0,0)
module vga_timing_gen #(
  parameter int   CNT_W  = 11,
  parameter int   H_ACT  = 800,
  parameter int   H_FP   = 40,
  parameter int   H_SYNC = 128,
  parameter int   H_BP   = 88,
  parameter int   V_ACT  = 600,
  parameter int   V_FP   = 1,
  parameter int   V_SYNC = 4,
  parameter int   V_BP   = 23,
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_h_act,
  input  logic [CNT_W-1:0] cfg_h_fp,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_bp,
  input  logic [CNT_W-1:0] cfg_v_act,
  input  logic [CNT_W-1:0] cfg_v_fp,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_bp,
  output logic             cfg_err,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  // Totals need two extra bits: four CNT_W fields can sum past 2^CNT_W.
  localparam int TW = CNT_W + 2;
  localparam logic [TW-1:0] MAX_TOT = TW'(1) << CNT_W;

  typedef struct packed {
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] fp;
    logic [CNT_W-1:0] sync;
    logic [CNT_W-1:0] bp;
  } axis_t;

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  localparam axis_t H_DEF = '{act: CNT_W'(H_ACT), fp: CNT_W'(H_FP), sync: CNT_W'(H_SYNC), bp: CNT_W'(H_BP)};
  localparam axis_t V_DEF = '{act: CNT_W'(V_ACT), fp: CNT_W'(V_FP), sync: CNT_W'(V_SYNC), bp: CNT_W'(V_BP)};

  function automatic logic [TW-1:0] total(input axis_t m);
    return TW'(m.act) + TW'(m.fp) + TW'(m.sync) + TW'(m.bp);
  endfunction

  function automatic logic mode_ok(input axis_t m);
    logic [TW-1:0] blank;
    blank = TW'(m.fp) + TW'(m.sync) + TW'(m.bp);
    return (m.act != '0) && (m.sync != '0) && (blank != '0) && (total(m) <= MAX_TOT);
  endfunction

  function automatic logic in_sync(input logic [CNT_W-1:0] c, input axis_t m);
    logic [TW-1:0] lo;
    lo = TW'(m.act) + TW'(m.fp);
    return (TW'(c) >= lo) && (TW'(c) < lo + TW'(m.sync));
  endfunction

  state_t           state_q, state_d;
  axis_t            h_mode_q, h_mode_d, v_mode_q, v_mode_d;
  axis_t            h_shd_q, h_shd_d, v_shd_q, v_shd_d;
  logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d, vblnk_q, vblnk_d, de_q, de_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic             cfg_err_q, cfg_err_d;

  axis_t            cfg_h, cfg_v;
  logic [TW-1:0]    ht, vt;
  logic             h_end, v_end;

  assign cfg_h = '{act: cfg_h_act, fp: cfg_h_fp, sync: cfg_h_sync, bp: cfg_h_bp};
  assign cfg_v = '{act: cfg_v_act, fp: cfg_v_fp, sync: cfg_v_sync, bp: cfg_v_bp};

  assign ht    = total(h_mode_q);
  assign vt    = total(v_mode_q);
  assign h_end = (TW'(hcount_q) == ht - TW'(1));
  assign v_end = (TW'(vcount_q) == vt - TW'(1));

  always_comb begin
    state_d       = state_q;
    h_mode_d      = h_mode_q;
    v_mode_d      = v_mode_q;
    h_shd_d       = h_shd_q;
    v_shd_d       = v_shd_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    cfg_err_d     = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    // A switch is tested against the pre-switch state, so an offer landing in
    // the switch cycle sees cfg_ready=0 and is taken on the following clk.
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          h_shd_d = cfg_h;
          v_shd_d = cfg_v;
          if (mode_ok(cfg_h) && mode_ok(cfg_v)) begin
            state_d = S_PEND;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_PEND: begin
        if (pix_en && h_end && v_end) begin
          h_mode_d = h_shd_q;
          v_mode_d = v_shd_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pix_en) begin
      if (h_end) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (v_end) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 1'b1;
        end
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end

    // Flags come from the next counts and the mode in force next cycle; with
    // pix_en low neither changes, so the flags hold without an explicit mux.
    hblnk_d = (TW'(hcount_d) >= TW'(h_mode_d.act));
    vblnk_d = (TW'(vcount_d) >= TW'(v_mode_d.act));
    hsync_d = in_sync(hcount_d, h_mode_d) ? HS_POL : ~HS_POL;
    vsync_d = in_sync(vcount_d, v_mode_d) ? VS_POL : ~VS_POL;
    de_d    = ~hblnk_d & ~vblnk_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      h_mode_q      <= H_DEF;
      v_mode_q      <= V_DEF;
      h_shd_q       <= H_DEF;
      v_shd_q       <= V_DEF;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_mode_q      <= h_mode_d;
      v_mode_q      <= v_mode_d;
      h_shd_q       <= h_shd_d;
      v_shd_q       <= v_shd_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign cfg_ready   = (state_q == S_IDLE);
  assign cfg_err     = cfg_err_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: directed self-checking bench for vga_timing_gen using a small reset mode (15x8 total).
// Latency: every clk is compared one time unit after the rising edge.
// Backpressure: exercises cfg_ready hold-off during pending switches and pix_en stalls.
module tb_vga_timing_gen;

  localparam int CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, pix_en, cfg_valid;
  logic [CW-1:0] ch [4];
  logic [CW-1:0] cv [4];

  logic          cfg_ready, cfg_err, hsync, vsync, hblnk, vblnk, de, line_start, frame_start;
  logic [CW-1:0] hcount, vcount;
  logic          b_cfg_ready, b_cfg_err, b_hsync, b_vsync, b_hblnk, b_vblnk, b_de, b_line_start, b_frame_start;
  logic [CW-1:0] b_hcount, b_vcount;

  vga_timing_gen #(
    .CNT_W(CW), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_act(ch[0]), .cfg_h_fp(ch[1]), .cfg_h_sync(ch[2]), .cfg_h_bp(ch[3]),
    .cfg_v_act(cv[0]), .cfg_v_fp(cv[1]), .cfg_v_sync(cv[2]), .cfg_v_bp(cv[3]),
    .cfg_err(cfg_err), .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblnk(hblnk), .vblnk(vblnk), .de(de), .line_start(line_start), .frame_start(frame_start)
  );

  // Same stimulus, active-low syncs.
  vga_timing_gen #(
    .CNT_W(CW), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_neg (
    .clk(clk), .rst(rst), .pix_en(pix_en), .cfg_valid(cfg_valid), .cfg_ready(b_cfg_ready),
    .cfg_h_act(ch[0]), .cfg_h_fp(ch[1]), .cfg_h_sync(ch[2]), .cfg_h_bp(ch[3]),
    .cfg_v_act(cv[0]), .cfg_v_fp(cv[1]), .cfg_v_sync(cv[2]), .cfg_v_bp(cv[3]),
    .cfg_err(b_cfg_err), .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
    .hblnk(b_hblnk), .vblnk(b_vblnk), .de(b_de), .line_start(b_line_start), .frame_start(b_frame_start)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int mh [4];
  int mv [4];
  int sh [4];
  int sv [4];
  int eh, ev;
  bit pend, e_ls, e_fs, e_err, offer_ok;

  // Observed statistics.
  int cyc_no, n_de, n_fs, n_ls, n_hs, n_vs, fs_prev, fs_last, hmax;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clr_stats();
    n_de = 0; n_fs = 0; n_ls = 0; n_hs = 0; n_vs = 0; hmax = 0;
  endtask

  task automatic set_cfg(input int ha, input int hf, input int hs, input int hb,
                         input int va, input int vf, input int vs, input int vb, input bit ok);
    ch[0] = CW'(ha); ch[1] = CW'(hf); ch[2] = CW'(hs); ch[3] = CW'(hb);
    cv[0] = CW'(va); cv[1] = CW'(vf); cv[2] = CW'(vs); cv[3] = CW'(vb);
    offer_ok = ok;
  endtask

  // One clk: advance the model, then compare every output of both instances.
  task automatic cyc(input string tag);
    bit was_pend;
    int ht, vt;
    bit hs, vs, hb, vb;
    logic [55:0] obs, expv;
    was_pend = pend;
    @(posedge clk);
    cyc_no++;
    e_ls = 0; e_fs = 0; e_err = 0;
    if (rst) begin
      eh = 0; ev = 0; pend = 0;
      mh = '{8, 2, 3, 2};
      mv = '{4, 1, 2, 1};
    end else begin
      ht = mh[0] + mh[1] + mh[2] + mh[3];
      vt = mv[0] + mv[1] + mv[2] + mv[3];
      if (cfg_valid && !was_pend) begin
        if (offer_ok) begin
          pend = 1;
          for (int i = 0; i < 4; i++) begin
            sh[i] = int'(ch[i]);
            sv[i] = int'(cv[i]);
          end
        end else begin
          e_err = 1;
        end
      end
      if (pix_en) begin
        if (eh == ht - 1) begin
          eh = 0; e_ls = 1;
          if (ev == vt - 1) begin
            ev = 0; e_fs = 1;
            if (was_pend) begin
              mh = sh; mv = sv; pend = 0;
            end
          end else begin
            ev++;
          end
        end else begin
          eh++;
        end
      end
    end
    #1;
    hb = (eh >= mh[0]);
    vb = (ev >= mv[0]);
    hs = (eh >= mh[0] + mh[1]) && (eh < mh[0] + mh[1] + mh[2]);
    vs = (ev >= mv[0] + mv[1]) && (ev < mv[0] + mv[1] + mv[2]);
    obs  = {hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start,
            cfg_ready, cfg_err, b_hsync, b_vsync, b_hcount, b_vcount, b_de};
    expv = {CW'(eh), CW'(ev), hs, vs, hb, vb, (!hb && !vb), e_ls, e_fs,
            !pend, e_err, !hs, !vs, CW'(eh), CW'(ev), (!hb && !vb)};
    check(tag, 64'(obs), 64'(expv));
    n_de += int'(de);
    n_fs += int'(frame_start);
    n_ls += int'(line_start);
    n_hs += int'(hsync);
    n_vs += int'(vsync);
    if (int'(hcount) > hmax) hmax = int'(hcount);
    if (frame_start) begin
      fs_prev = fs_last;
      fs_last = cyc_no;
    end
  endtask

  initial begin
    cyc_no = 0; fs_prev = 0; fs_last = 0;
    eh = 0; ev = 0; pend = 0;
    mh = '{8, 2, 3, 2};
    mv = '{4, 1, 2, 1};
    sh = mh; sv = mv;
    rst = 1'b1; pix_en = 1'b0; cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    clr_stats();

    // Reset state, compared against literal values.
    cyc("reset");
    cyc("reset");
    check("reset_outputs",
          64'({hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start,
               cfg_ready, cfg_err, b_hsync, b_vsync}),
          64'({11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}));

    // Two full frames of the reset mode.
    rst = 1'b0; pix_en = 1'b1;
    clr_stats();
    repeat (240) cyc("run_default");
    check("de_count", 64'(n_de), 64'd64);
    check("frame_start_count", 64'(n_fs), 64'd2);
    check("line_start_count", 64'(n_ls), 64'd16);
    check("hsync_cycles", 64'(n_hs), 64'd48);
    check("vsync_cycles", 64'(n_vs), 64'd60);
    check("frame_len_default", 64'(fs_last - fs_prev), 64'd120);

    // pix_en one cycle in four: 60 pixels, 4 line wraps, each pulse one clk.
    clr_stats();
    for (int i = 0; i < 60; i++) begin
      pix_en = 1'b1;
      cyc("slow_step");
      pix_en = 1'b0;
      repeat (3) cyc("slow_hold");
    end
    check("slow_line_starts", 64'(n_ls), 64'd4);
    check("slow_de_cycles", 64'(n_de), 64'd124);
    check("slow_end_pos", 64'({hcount, vcount}), 64'({11'd0, 11'd4}));
    pix_en = 1'b1;

    // Mid-frame offer of a smaller mode (10x6 total); offers while pending are ignored.
    set_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1);
    cfg_valid = 1'b1;
    cyc("offer_small");
    check("ready_low_pending", 64'(cfg_ready), 64'd0);
    set_cfg(0, 1, 2, 1, 3, 1, 1, 1, 1'b0);
    repeat (3) cyc("offer_ignored");
    cfg_valid = 1'b0;
    repeat (200) cyc("run_small");
    check("frame_len_small", 64'(fs_last - fs_prev), 64'd60);
    check("ready_back", 64'(cfg_ready), 64'd1);

    // Rejected offers: zero h_act, then HT=2100 > 2048.
    set_cfg(0, 16, 96, 48, 4, 1, 2, 1, 1'b0);
    cfg_valid = 1'b1;
    cyc("reject_act0");
    check("err_act0", 64'(cfg_err), 64'd1);
    cfg_valid = 1'b0;
    cyc("reject_act0_drop");
    set_cfg(2000, 50, 40, 10, 4, 1, 2, 1, 1'b0);
    cfg_valid = 1'b1;
    cyc("reject_ht2100");
    check("err_ht2100", 64'(cfg_err), 64'd1);
    cfg_valid = 1'b0;
    repeat (130) cyc("after_reject");
    check("frame_len_unchanged", 64'(fs_last - fs_prev), 64'd60);

    // Minimum legal mode offered and held across the switch cycle.
    set_cfg(1, 0, 1, 0, 1, 0, 1, 0, 1'b1);
    cfg_valid = 1'b1;
    repeat (80) cyc("min_mode_held");
    cfg_valid = 1'b0;
    clr_stats();
    repeat (12) cyc("min_mode");
    check("min_frame_starts", 64'(n_fs), 64'd3);

    // HT = 2^CNT_W is legal and wraps naturally.
    set_cfg(2000, 0, 40, 8, 1, 0, 1, 0, 1'b1);
    cfg_valid = 1'b1;
    cyc("offer_2048");
    cfg_valid = 1'b0;
    check("err_2048", 64'(cfg_err), 64'd0);
    clr_stats();
    repeat (4110) cyc("run_2048");
    check("hcount_max_2048", 64'(hmax), 64'd2047);
    check("frame_len_2048", 64'(fs_last - fs_prev), 64'd4096);

    // Reset with a mode pending: back to (0,0) in the reset mode, pending dropped.
    set_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1);
    cfg_valid = 1'b1;
    cyc("offer_before_rst");
    cfg_valid = 1'b0;
    repeat (100) cyc("pending_run");
    rst = 1'b1;
    cyc("mid_reset");
    check("mid_reset_pos_ready", 64'({hcount, vcount, de, cfg_ready}), 64'({11'd0, 11'd0, 1'b1, 1'b1}));
    rst = 1'b0;
    repeat (250) cyc("after_reset");
    check("frame_len_after_reset", 64'(fs_last - fs_prev), 64'd120);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised, run-time reconfigurable VGA timing generator and the next generation of the fixed-mode timing controller. It generates pixel/line counters, sync, blanking and data-enable signals for any mode whose line and frame totals fit in `CNT_W` bits. A pixel-clock enable lets it run from the system clock. A config handshake loads a new mode, which takes effect only at a frame boundary. It sits at the head of the draw pipeline and feeds `hcount`/`vcount`/sync/blank to every downstream draw stage.

## Interface
- `CNT_W`, 11, width of counters and timing fields
- `H_ACT`, 800; `H_FP`, 40; `H_SYNC`, 128; `H_BP`, 88: reset horizontal mode (total 1056)
- `V_ACT`, 600; `V_FP`, 1; `V_SYNC`, 4; `V_BP`, 23: reset vertical mode (total 628)
- `HS_POL`, 1; `VS_POL`, 1: active level of hsync/vsync
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel-clock enable; counters advance only when high
- `cfg_valid`  in  1  new mode offered
- `cfg_ready`  out  1  mode can be accepted
- `cfg_h_act`, `cfg_h_fp`, `cfg_h_sync`, `cfg_h_bp`  in  CNT_W each  horizontal fields
- `cfg_v_act`, `cfg_v_fp`, `cfg_v_sync`, `cfg_v_bp`  in  CNT_W each  vertical fields
- `cfg_err`  out  1  one-cycle pulse: offered mode rejected
- `hcount`, `vcount`  out  CNT_W  current pixel position
- `hsync`, `vsync`, `hblnk`, `vblnk`, `de`  out  1  timing flags, aligned with the counts
- `line_start`, `frame_start`  out  1  one-cycle pulses

## Operation
- Totals are computed in CNT_W+2 bits: `HT = h_act+h_fp+h_sync+h_bp`, and the same for `VT`.
- `hcount` runs 0..HT-1 and wraps. `vcount` increments when `hcount` wraps, runs 0..VT-1 and wraps.
- Flags are a function of the count values presented in the same cycle. They are registered from the next-count value, so there is zero skew against `hcount`/`vcount`.
  - `hblnk` = hcount ≥ h_act
  - `hsync` = HS_POL while h_act+h_fp ≤ hcount < h_act+h_fp+h_sync, else ~HS_POL
  - vertical flags follow the same rules on `vcount`
  - `de` = ~hblnk & ~vblnk
- `pix_en` = 0 means counters and all flags hold their values.
- `line_start` pulses for one clk when the counters transition to hcount=0.
- `frame_start` pulses for one clk when the counters transition to (0,0). `line_start` also fires in that cycle.
- Both pulses drop on the next clk regardless of `pix_en`.
- Config states:
  - IDLE: `cfg_ready` = 1. On `cfg_valid & cfg_ready`, fields are captured into shadow registers and validated in the same cycle.
    - The mode is rejected if any of act, sync or (fp+sync+bp) is 0, or if HT or VT > 2^CNT_W. Rejection pulses `cfg_err` for one cycle and the block stays in IDLE.
    - Otherwise the block goes to PENDING.
  - PENDING: `cfg_ready` = 0. The shadow mode is copied into the active mode on the `pix_en` cycle where hcount=HT-1 and vcount=VT-1, and the counters go to (0,0) under the new mode. The block then returns to IDLE.
- The running frame always completes under the old mode. A mode is never switched mid-frame.

## Timing
- Reset values:
  - hcount=0, vcount=0
  - hblnk=0, vblnk=0, de=1
  - hsync=~HS_POL, vsync=~VS_POL
  - line_start=0, frame_start=0
  - cfg_ready=1, cfg_err=0
  - active mode = parameter mode; shadow mode discarded
- Counter latency: one `pix_en` cycle per pixel. There is no pipeline delay between counts and flags.
- Reset mid-operation: the next cycle shows the reset values and any pending mode is dropped. Reset has priority over `pix_en` and `cfg_valid`.
- `cfg_valid` while `cfg_ready` = 0 is ignored; no `cfg_err` is raised.
- A switch cycle and a new `cfg_valid` in the same clk: the switch completes. The new offer is accepted on the next clk, where `cfg_ready` = 1.
- Boundary conditions:
  - HT = 2^CNT_W is legal; the counter wraps naturally.
  - Minimum legal mode is act=1, sync=1, fp=bp=0.

## Test plan
- Reset, then run 2 frames of the default mode with `pix_en`=1 -> 1056×628 clks per frame; hsync high for hcount 840..967; vsync high for vcount 601..604; `de` count = 480000; one `frame_start` per frame.
- `pix_en` toggling 1-of-4 -> identical count/flag sequence stretched ×4; `line_start` exactly one clk wide.
- Offer 640×480 (H 640/16/96/48, V 480/10/2/33) at vcount=300 -> `cfg_ready`=0 until end of frame; next frame is 800×525 total; `cfg_ready` returns to 1.
- Offer h_act=0, then HT=2100 with CNT_W=11 -> `cfg_err` one-cycle pulse each time; timing unchanged; `cfg_ready` stays 1.
- HS_POL=0, VS_POL=0 build -> sync outputs idle high, low during the sync intervals; reset value high.
- Assert `rst` at (500,300) with a mode pending -> the next cycle shows (0,0) in the default mode; the pending mode is never applied.
